// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and external bus seen by mem_port_arbiter.
// slave is the arbiter side; master is the core/memory side.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic            i_i_req;
    logic [XLEN-1:0] i_i_addr;
    logic            o_i_ready;
    logic [XLEN-1:0] o_i_rdata;
    logic            o_i_err;

    logic            i_d_req;
    logic            i_d_wen;
    logic [XLEN-1:0] i_d_addr;
    logic [XLEN-1:0] i_d_wd;
    logic [2:0]      i_d_f3;
    logic            o_d_ready;
    logic [XLEN-1:0] o_d_rdata;
    logic            o_d_err;

    logic            o_bus_req;
    logic            o_bus_wen;
    logic [XLEN-1:0] o_bus_addr;
    logic [XLEN-1:0] o_bus_wd;
    logic [2:0]      o_bus_f3;
    logic            i_bus_ready;
    logic [XLEN-1:0] i_bus_rdata;

    logic [1:0]      o_grant;

    modport slave (
        input  i_i_req, i_i_addr,
        output o_i_ready, o_i_rdata, o_i_err,
        input  i_d_req, i_d_wen, i_d_addr, i_d_wd, i_d_f3,
        output o_d_ready, o_d_rdata, o_d_err,
        output o_bus_req, o_bus_wen, o_bus_addr, o_bus_wd, o_bus_f3,
        input  i_bus_ready, i_bus_rdata,
        output o_grant
    );

    modport master (
        output i_i_req, i_i_addr,
        input  o_i_ready, o_i_rdata, o_i_err,
        output i_d_req, i_d_wen, i_d_addr, i_d_wd, i_d_f3,
        input  o_d_ready, o_d_rdata, o_d_err,
        input  o_bus_req, o_bus_wen, o_bus_addr, o_bus_wd, o_bus_f3,
        output i_bus_ready, i_bus_rdata,
        input  o_grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the I-cache refill port and the data port.
// Data has priority; fetch is forced through after STARVE_LIMIT losses.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 256
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mem_port_arbiter_if.slave  port
);
    localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [SW-1:0] S_MAX  = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [2:0]    F3_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   starve;
    logic [TW-1:0]   tcnt;

    logic            i_ready;
    logic [XLEN-1:0] i_rdata;
    logic            i_err;
    logic            d_ready;
    logic [XLEN-1:0] d_rdata;
    logic            d_err;
    logic            bus_req;
    logic            bus_wen;
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wd;
    logic [2:0]      bus_f3;
    logic [1:0]      grant;

    logic            starved;
    logic            pick_i;
    logic            pick_d;
    logic            expired;
    logic            hit;
    logic [XLEN-1:0] done_data;

    assign starved = (STARVE_LIMIT != 0) && (starve >= S_MAX);
    assign pick_i  = port.i_i_req && (!port.i_d_req || starved);
    assign pick_d  = port.i_d_req && !pick_i;
    assign expired = (TIMEOUT != 0) && (tcnt == T_LAST);
    assign hit     = port.i_bus_ready;
    // A timeout returns zero data; a real completion wins on the last count.
    assign done_data = hit ? port.i_bus_rdata : '0;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            starve   <= '0;
            tcnt     <= '0;
            i_ready  <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_ready  <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
            bus_req  <= 1'b0;
            bus_wen  <= 1'b0;
            bus_addr <= '0;
            bus_wd   <= '0;
            bus_f3   <= '0;
            grant    <= 2'b00;
        end else begin
            unique case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (pick_i) begin
                        bus_req  <= 1'b1;
                        bus_wen  <= 1'b0;
                        bus_addr <= port.i_i_addr;
                        bus_wd   <= '0;
                        bus_f3   <= F3_WORD;
                        grant    <= 2'b01;
                        starve   <= '0;
                        state    <= BUSY_I;
                    end else if (pick_d) begin
                        bus_req  <= 1'b1;
                        bus_wen  <= port.i_d_wen;
                        bus_addr <= port.i_d_addr;
                        bus_wd   <= port.i_d_wd;
                        bus_f3   <= port.i_d_f3;
                        grant    <= 2'b10;
                        state    <= BUSY_D;
                        if (port.i_i_req && starve != S_MAX) begin
                            starve <= starve + 1'b1;
                        end
                    end
                end
                BUSY_I: begin
                    if (hit || expired) begin
                        i_ready <= 1'b1;
                        i_err   <= !hit;
                        i_rdata <= done_data;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                BUSY_D: begin
                    if (hit || expired) begin
                        d_ready <= 1'b1;
                        d_err   <= !hit;
                        d_rdata <= done_data;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                DONE: begin
                    i_ready <= 1'b0;
                    i_err   <= 1'b0;
                    d_ready <= 1'b0;
                    d_err   <= 1'b0;
                    grant   <= 2'b00;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign port.o_i_ready  = i_ready;
    assign port.o_i_rdata  = i_rdata;
    assign port.o_i_err    = i_err;
    assign port.o_d_ready  = d_ready;
    assign port.o_d_rdata  = d_rdata;
    assign port.o_d_err    = d_err;
    assign port.o_bus_req  = bus_req;
    assign port.o_bus_wen  = bus_wen;
    assign port.o_bus_addr = bus_addr;
    assign port.o_bus_wd   = bus_wd;
    assign port.o_bus_f3   = bus_f3;
    assign port.o_grant    = grant;
endmodule
